// File: rtl/pid_motor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pid_motor_pkg
// Brief    : Shared constants, channel state type and width helper for the
//            PID-to-motor PWM path.
// Revision : 1.0  initial release
// ============================================================================
package pid_motor_pkg;

    localparam int DATA_WIDTH      = 16;
    localparam int NUM_CHN         = 4;
    localparam int CHN_WIDTH       = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
    localparam int PWM_PERIOD      = 1000;
    localparam int DEAD_PERIODS    = 2;
    localparam int TIMEOUT_PERIODS = 500;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DEAD = 1'b1
    } chn_state_t;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_chn_slice.sv
`default_nettype none
// ============================================================================
// Module   : pwm_chn_slice
// Brief    : One motor channel: shadow request, |u| saturation, RUN/DEAD
//            reversal FSM, watchdog and registered PWM comparator.
// Revision : 1.0  initial release
// ============================================================================
module pwm_chn_slice #(
    parameter int DATA_WIDTH      = 16,
    parameter int PWM_PERIOD      = 1000,
    parameter int DEAD_PERIODS    = 2,
    parameter int TIMEOUT_PERIODS = 500,
    parameter int CNT_WIDTH       = 10,
    parameter int DUTY_WIDTH      = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  boundary_i,
    input  logic [CNT_WIDTH-1:0]  cnt_next_i,
    output logic                  pwm_o,
    output logic                  dir_o,
    output logic                  timeout_o
);
    import pid_motor_pkg::*;

    localparam int DEAD_WIDTH = clog2_min1(DEAD_PERIODS + 1);
    localparam int WD_WIDTH   = clog2_min1(TIMEOUT_PERIODS + 1);
    localparam logic [DEAD_WIDTH-1:0] DEAD_INIT = DEAD_WIDTH'(DEAD_PERIODS);
    localparam logic [WD_WIDTH-1:0]   WD_LIMIT  = WD_WIDTH'(TIMEOUT_PERIODS);
    localparam logic [DATA_WIDTH:0]   SAT_LEVEL = (DATA_WIDTH + 1)'(PWM_PERIOD);
    localparam logic [DUTY_WIDTH-1:0] DUTY_FULL = DUTY_WIDTH'(PWM_PERIOD);

    chn_state_t            state_q, state_d;
    logic                  dir_q, dir_d;
    logic                  timeout_q, timeout_d;
    logic                  pwm_q, pwm_d;
    logic                  shadow_neg_q, shadow_neg_d;
    logic [DUTY_WIDTH-1:0] shadow_mag_q, shadow_mag_d;
    logic [DUTY_WIDTH-1:0] duty_q, duty_d;
    logic [DEAD_WIDTH-1:0] dead_cnt_q, dead_cnt_d;
    logic [WD_WIDTH-1:0]   wd_cnt_q, wd_cnt_d;

    logic [DATA_WIDTH:0]   data_ext;
    logic [DATA_WIDTH:0]   data_abs;
    logic [DUTY_WIDTH-1:0] req_mag;
    logic                  req_neg;

    // One extra bit so that |-2^(DW-1)| is representable before saturation.
    always_comb begin
        data_ext = {data_i[DATA_WIDTH-1], data_i};
        data_abs = data_i[DATA_WIDTH-1] ? -data_ext : data_ext;
        req_mag  = (data_abs > SAT_LEVEL) ? DUTY_FULL : DUTY_WIDTH'(data_abs);
        req_neg  = (req_mag == '0) ? dir_q : data_i[DATA_WIDTH-1];
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        duty_d       = duty_q;
        dead_cnt_d   = dead_cnt_q;
        wd_cnt_d     = wd_cnt_q;
        timeout_d    = timeout_q;
        shadow_neg_d = shadow_neg_q;
        shadow_mag_d = shadow_mag_q;

        if (boundary_i) begin
            case (state_q)
                RUN: begin
                    if ((shadow_neg_q != dir_q) && (shadow_mag_q != '0)) begin
                        state_d    = DEAD;
                        duty_d     = '0;
                        dead_cnt_d = DEAD_INIT;
                    end else begin
                        duty_d = shadow_mag_q;
                    end
                end
                DEAD: begin
                    dead_cnt_d = dead_cnt_q - DEAD_WIDTH'(1);
                    if (dead_cnt_q == DEAD_WIDTH'(1)) begin
                        state_d = RUN;
                        dir_d   = shadow_neg_q;
                        duty_d  = shadow_mag_q;
                    end
                end
                default: state_d = RUN;
            endcase

            if ((TIMEOUT_PERIODS != 0) && (wd_cnt_q != WD_LIMIT)) begin
                wd_cnt_d = wd_cnt_q + WD_WIDTH'(1);
                if (wd_cnt_d == WD_LIMIT) begin
                    shadow_mag_d = '0;
                    timeout_d    = 1'b1;
                end
            end
        end

        // A strobe coinciding with watchdog expiry overrides it.
        if (wr_i) begin
            shadow_neg_d = req_neg;
            shadow_mag_d = req_mag;
            wd_cnt_d     = '0;
            timeout_d    = 1'b0;
        end

        pwm_d = (state_d == RUN) && (DUTY_WIDTH'(cnt_next_i) < duty_d);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= RUN;
            dir_q        <= 1'b0;
            duty_q       <= '0;
            dead_cnt_q   <= '0;
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
            shadow_neg_q <= 1'b0;
            shadow_mag_q <= '0;
            pwm_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            duty_q       <= duty_d;
            dead_cnt_q   <= dead_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
            timeout_q    <= timeout_d;
            shadow_neg_q <= shadow_neg_d;
            shadow_mag_q <= shadow_mag_d;
            pwm_q        <= pwm_d;
        end
    end

    assign pwm_o     = pwm_q;
    assign dir_o     = dir_q;
    assign timeout_o = timeout_q;

endmodule
`default_nettype wire

// File: rtl/pwm_motor_driver.sv
`default_nettype none
// ============================================================================
// Module   : pwm_motor_driver
// Brief    : Multi-channel sign/magnitude PWM driver fed by the PID output
//            stream; shared period counter plus one slice per channel.
// Revision : 1.0  initial release
// ============================================================================
module pwm_motor_driver #(
    parameter int  DATA_WIDTH      = pid_motor_pkg::DATA_WIDTH,
    parameter int  NUM_CHN         = pid_motor_pkg::NUM_CHN,
    parameter int  PWM_PERIOD      = pid_motor_pkg::PWM_PERIOD,
    parameter int  DEAD_PERIODS    = pid_motor_pkg::DEAD_PERIODS,
    parameter int  TIMEOUT_PERIODS = pid_motor_pkg::TIMEOUT_PERIODS,
    localparam int CHN_WIDTH       = pid_motor_pkg::clog2_min1(NUM_CHN),
    localparam int CNT_WIDTH       = pid_motor_pkg::clog2_min1(PWM_PERIOD)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  u_valid_i,
    input  logic [CHN_WIDTH-1:0]  u_chn_i,
    input  logic [DATA_WIDTH-1:0] u_data_i,
    output logic [NUM_CHN-1:0]    pwm_o,
    output logic [NUM_CHN-1:0]    dir_o,
    output logic [NUM_CHN-1:0]    timeout_o,
    output logic                  period_start_o
);
    import pid_motor_pkg::*;

    // Duty must be able to hold PWM_PERIOD itself (full scale).
    localparam int DUTY_WIDTH = clog2_min1(PWM_PERIOD + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(PWM_PERIOD - 1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 period_start_q, period_start_d;
    logic                 boundary;
    logic                 chn_ok;
    logic [NUM_CHN-1:0]   chn_wr;

    always_comb begin
        boundary       = (cnt_q == CNT_LAST);
        cnt_d          = boundary ? '0 : cnt_q + CNT_WIDTH'(1);
        period_start_d = (cnt_d == '0);
        chn_ok         = u_valid_i && ({1'b0, u_chn_i} < (CHN_WIDTH + 1)'(NUM_CHN));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            period_start_q <= period_start_d;
        end
    end

    assign period_start_o = period_start_q;

    generate
        for (genvar i = 0; i < NUM_CHN; i++) begin : g_chn
            assign chn_wr[i] = chn_ok && (u_chn_i == CHN_WIDTH'(i));

            pwm_chn_slice #(
                .DATA_WIDTH      (DATA_WIDTH),
                .PWM_PERIOD      (PWM_PERIOD),
                .DEAD_PERIODS    (DEAD_PERIODS),
                .TIMEOUT_PERIODS (TIMEOUT_PERIODS),
                .CNT_WIDTH       (CNT_WIDTH),
                .DUTY_WIDTH      (DUTY_WIDTH)
            ) u_slice (
                .clk        (clk),
                .rstn       (rstn),
                .wr_i       (chn_wr[i]),
                .data_i     (u_data_i),
                .boundary_i (boundary),
                .cnt_next_i (cnt_d),
                .pwm_o      (pwm_o[i]),
                .dir_o      (dir_o[i]),
                .timeout_o  (timeout_o[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire
